// File: rtl/level_ram_port_arb.sv
// -----------------------------------------------------------------------------
// level_ram_port_arb
//
// Port arbiter and sequencer for one pipelined-heap level RAM (true dual-port,
// 1-cycle read latency, no-change on write).
//   - The pipeline stage has absolute priority: op reads always use port A and
//     op writes always use port B, every cycle if needed.
//   - A host/debug requester borrows whichever port the pipeline leaves idle
//     (A first, then B). host_gnt is combinational; the access happens in the
//     grant cycle.
//   - After reset the RAM is cleared two words per cycle (optional).
//   - A read that hits an address written by the other port in the same cycle
//     returns the written data instead of the RAM output.
//
// Configuration macro:
//   LEVEL_ARB_INIT_EN  defined   -> INIT state clears the RAM after reset.
//                      undefined -> starts in RUN, init_busy = 0, err_drop
//                                   never sets.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   op_rd_req/addr                pipeline read request (port A)
//   op_rd_valid/data              pipeline read result, one cycle later
//   op_wr_req/addr/data           pipeline write request (port B)
//   host_req/we/addr/wdata        host request, held until host_gnt
//   host_gnt                      combinational grant
//   host_rvalid/rdata             host read result, one cycle after grant
//   ram_we/addr/data_a/b          RAM port controls
//   ram_q_a/b                     RAM read data (1-cycle latency)
//   init_busy                     RAM clear in progress
//   err_drop                      sticky: pipeline request dropped during INIT
// -----------------------------------------------------------------------------

package pheapTypes;
    typedef logic [15:0] entry_t;
endpackage

module level_ram_port_arb #(
    parameter int  RAMLEVEL = 2,
    parameter int  DW       = $bits(pheapTypes::entry_t),
    localparam int AW       = RAMLEVEL - 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_rd_req,
    input  logic [AW-1:0] op_rd_addr,
    output logic          op_rd_valid,
    output logic [DW-1:0] op_rd_data,
    input  logic          op_wr_req,
    input  logic [AW-1:0] op_wr_addr,
    input  logic [DW-1:0] op_wr_data,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          ram_we_a,
    output logic          ram_we_b,
    output logic [AW-1:0] ram_addr_a,
    output logic [AW-1:0] ram_addr_b,
    output logic [DW-1:0] ram_data_a,
    output logic [DW-1:0] ram_data_b,
    input  logic [DW-1:0] ram_q_a,
    input  logic [DW-1:0] ram_q_b,
    output logic          init_busy,
    output logic          err_drop
);

`ifdef LEVEL_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    localparam int DEPTH = 2 ** AW;
    localparam int PAIRS = DEPTH / 2;
    localparam int KW    = (AW > 1) ? AW - 1 : 1;

    typedef enum logic {S_INIT, S_RUN} state_t;
    // Where a read result comes from in the cycle after issue.
    typedef enum logic [1:0] {SRC_A, SRC_B, SRC_FWD} src_t;

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic          r_init_busy;
    logic          r_err_drop;
    logic          r_op_valid;
    src_t          r_op_src;
    logic [DW-1:0] r_op_fwd;
    logic          r_host_valid;
    src_t          r_host_src;
    logic [DW-1:0] r_host_fwd;

    logic          w_run;
    logic          w_host_a;
    logic          w_host_b;
    logic          w_op_rd;
    logic          w_host_rd;
    logic          w_fwd_a;
    logic          w_fwd_b;
    logic [AW-1:0] w_init_addr_a;
    logic [AW-1:0] w_init_addr_b;

    assign w_init_addr_a = AW'({r_k, 1'b0});
    assign w_init_addr_b = AW'({r_k, 1'b1});

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_run      = 1'b0;
        w_host_a   = 1'b0;
        w_host_b   = 1'b0;
        ram_we_a   = 1'b0;
        ram_we_b   = 1'b0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_data_a = '0;
        ram_data_b = '0;
        // NOTE: rst also gates these combinational controls so the RAM sees
        // no access while reset is held, not just after the next edge.
        if (!rst) begin
            if (r_state == S_INIT) begin
                ram_we_a   = 1'b1;
                ram_addr_a = w_init_addr_a;
                ram_we_b   = 1'b1;
                ram_addr_b = w_init_addr_b;
            end else begin
                w_run = 1'b1;
                // A host write colliding with the pipeline write is refused
                // rather than ordered; the host simply retries.
                w_host_a = host_req && !op_rd_req &&
                           !(host_we && op_wr_req && host_addr == op_wr_addr);
                w_host_b = host_req && op_rd_req && !op_wr_req;

                if (op_rd_req) begin
                    ram_addr_a = op_rd_addr;
                end else if (w_host_a) begin
                    ram_we_a   = host_we;
                    ram_addr_a = host_addr;
                    ram_data_a = host_we ? host_wdata : '0;
                end

                if (op_wr_req) begin
                    ram_we_b   = 1'b1;
                    ram_addr_b = op_wr_addr;
                    ram_data_b = op_wr_data;
                end else if (w_host_b) begin
                    ram_we_b   = host_we;
                    ram_addr_b = host_addr;
                    ram_data_b = host_we ? host_wdata : '0;
                end
            end
        end
    end

    assign host_gnt  = w_host_a || w_host_b;
    assign w_op_rd   = w_run && op_rd_req;
    assign w_host_rd = host_gnt && !host_we;
    // A read on one port is forwarded when the other port writes the same word.
    assign w_fwd_a   = ram_we_b && (ram_addr_b == ram_addr_a);
    assign w_fwd_b   = ram_we_a && (ram_addr_a == ram_addr_b);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= INIT_EN ? S_INIT : S_RUN;
            r_k          <= '0;
            r_init_busy  <= INIT_EN;
            r_err_drop   <= 1'b0;
            r_op_valid   <= 1'b0;
            r_op_src     <= SRC_A;
            r_op_fwd     <= '0;
            r_host_valid <= 1'b0;
            r_host_src   <= SRC_A;
            r_host_fwd   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (op_rd_req || op_wr_req) r_err_drop <= 1'b1;
                    if (r_k == KW'(PAIRS - 1)) begin
                        r_state     <= S_RUN;
                        r_init_busy <= 1'b0;
                        r_k         <= '0;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: ;
            endcase

            r_op_valid <= w_op_rd;
            if (w_op_rd) begin
                r_op_src <= w_fwd_a ? SRC_FWD : SRC_A;
                r_op_fwd <= ram_data_b;
            end

            r_host_valid <= w_host_rd;
            if (w_host_rd) begin
                if (w_host_a) begin
                    r_host_src <= w_fwd_a ? SRC_FWD : SRC_A;
                    r_host_fwd <= ram_data_b;
                end else begin
                    r_host_src <= w_fwd_b ? SRC_FWD : SRC_B;
                    r_host_fwd <= ram_data_a;
                end
            end
        end
    end

    always_comb begin
        op_rd_data = '0;
        if (r_op_valid) op_rd_data = (r_op_src == SRC_FWD) ? r_op_fwd : ram_q_a;
        host_rdata = '0;
        if (r_host_valid) begin
            case (r_host_src)
                SRC_A:   host_rdata = ram_q_a;
                SRC_B:   host_rdata = ram_q_b;
                default: host_rdata = r_host_fwd;
            endcase
        end
    end

    assign op_rd_valid = r_op_valid;
    assign host_rvalid = r_host_valid;
    assign init_busy   = r_init_busy;
    assign err_drop    = r_err_drop;

endmodule

// File: tb/tb_level_ram_port_arb.sv
// Testbench for level_ram_port_arb (RAMLEVEL=3: 4 words, 2-bit address).
// Contains a behavioural dual-port RAM, a cycle model derived from the port
// rules, and directed stimulus with hand-computed expectations.
module tb_level_ram_port_arb;
    localparam int RAMLEVEL = 3;
    localparam int AW       = RAMLEVEL - 1;
    localparam int DEPTH    = 2 ** AW;
    localparam int PAIRS    = DEPTH / 2;
    localparam int DW       = 16;

`ifdef LEVEL_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          op_rd_req, op_wr_req, host_req, host_we;
    logic [AW-1:0] op_rd_addr, op_wr_addr, host_addr;
    logic [DW-1:0] op_wr_data, host_wdata;
    logic          op_rd_valid, host_gnt, host_rvalid;
    logic [DW-1:0] op_rd_data, host_rdata;
    logic          ram_we_a, ram_we_b;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic [DW-1:0] ram_data_a, ram_data_b;
    logic [DW-1:0] ram_q_a = '0;
    logic [DW-1:0] ram_q_b = '0;
    logic          init_busy, err_drop;

    int n_tests = 0;
    int n_fail  = 0;

    level_ram_port_arb #(.RAMLEVEL(RAMLEVEL), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .op_rd_req(op_rd_req), .op_rd_addr(op_rd_addr),
        .op_rd_valid(op_rd_valid), .op_rd_data(op_rd_data),
        .op_wr_req(op_wr_req), .op_wr_addr(op_wr_addr), .op_wr_data(op_wr_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b),
        .init_busy(init_busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: 1-cycle read, output holds on write, reads during a
    // write to the same word by the other port return the old contents.
    logic [DW-1:0] ram_mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_a;
        else          ram_q_a <= ram_mem[ram_addr_a];
        if (ram_we_b) ram_mem[ram_addr_b] <= ram_data_b;
        else          ram_q_b <= ram_mem[ram_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int            m_init_left = 0;
    logic          m_op_v = 1'b0, m_host_v = 1'b0, m_err = 1'b0;
    logic [DW-1:0] m_op_d = '0, m_host_d = '0;
    logic [DW-1:0] m_mem [DEPTH] = '{default: '0};

    always @(negedge clk) begin : model
        logic          ea_use, ea_we, eb_use, eb_we, e_gnt;
        logic [AW-1:0] ea_addr, eb_addr;
        logic [DW-1:0] ea_data, eb_data;
        logic [DW-1:0] nmem [DEPTH];
        int            k;
        if (rst) begin
            check("rst_op_rd_valid", op_rd_valid, 0);
            check("rst_op_rd_data",  op_rd_data,  0);
            check("rst_host_gnt",    host_gnt,    0);
            check("rst_host_rvalid", host_rvalid, 0);
            check("rst_host_rdata",  host_rdata,  0);
            check("rst_ram_a", {ram_we_a, ram_addr_a, ram_data_a}, 0);
            check("rst_ram_b", {ram_we_b, ram_addr_b, ram_data_b}, 0);
            check("rst_err_drop",    err_drop,    0);
            check("rst_init_busy",   init_busy,   INIT_EN);
            m_init_left = INIT_EN ? PAIRS : 0;
            m_op_v = 1'b0; m_host_v = 1'b0; m_err = 1'b0;
        end else begin
            // results registered from the previous cycle
            check("op_rd_valid", op_rd_valid, m_op_v);
            check("op_rd_data",  op_rd_data,  m_op_v ? m_op_d : '0);
            check("host_rvalid", host_rvalid, m_host_v);
            check("host_rdata",  host_rdata,  m_host_v ? m_host_d : '0);
            check("err_drop",    err_drop,    m_err);
            check("init_busy",   init_busy,   m_init_left > 0);
            for (int i = 0; i < DEPTH; i++) check($sformatf("mem[%0d]", i), ram_mem[i], m_mem[i]);

            // what this cycle must do
            ea_use = 0; ea_we = 0; ea_addr = '0; ea_data = '0;
            eb_use = 0; eb_we = 0; eb_addr = '0; eb_data = '0;
            e_gnt = 0;
            if (m_init_left > 0) begin
                k = PAIRS - m_init_left;
                ea_use = 1; ea_we = 1; ea_addr = AW'(2 * k);
                eb_use = 1; eb_we = 1; eb_addr = AW'(2 * k + 1);
            end else begin
                if (op_rd_req) begin
                    ea_use = 1; ea_addr = op_rd_addr;
                end else if (host_req && !(host_we && op_wr_req && host_addr == op_wr_addr)) begin
                    e_gnt = 1; ea_use = 1; ea_we = host_we; ea_addr = host_addr;
                    ea_data = host_we ? host_wdata : '0;
                end
                if (op_wr_req) begin
                    eb_use = 1; eb_we = 1; eb_addr = op_wr_addr; eb_data = op_wr_data;
                end else if (host_req && op_rd_req) begin
                    e_gnt = 1; eb_use = 1; eb_we = host_we; eb_addr = host_addr;
                    eb_data = host_we ? host_wdata : '0;
                end
            end
            check("host_gnt",   host_gnt,   e_gnt);
            check("ram_we_a",   ram_we_a,   ea_we);
            check("ram_addr_a", ram_addr_a, ea_addr);
            if (ea_we || !ea_use) check("ram_data_a", ram_data_a, ea_data);
            check("ram_we_b",   ram_we_b,   eb_we);
            check("ram_addr_b", ram_addr_b, eb_addr);
            if (eb_we || !eb_use) check("ram_data_b", ram_data_b, eb_data);

            // reads return memory as it stands after this cycle's writes
            nmem = m_mem;
            if (ea_we) nmem[ea_addr] = ea_data;
            if (eb_we) nmem[eb_addr] = eb_data;
            m_op_v   = (m_init_left == 0) && op_rd_req;
            m_op_d   = nmem[op_rd_addr];
            m_host_v = e_gnt && !host_we;
            m_host_d = nmem[host_addr];
            if (m_init_left > 0 && (op_rd_req || op_wr_req)) m_err = 1'b1;
            m_mem = nmem;
            if (m_init_left > 0) m_init_left--;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op_rd_req = 0; op_rd_addr = '0;
        op_wr_req = 0; op_wr_addr = '0; op_wr_data = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 0;
        #2 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;                                  // cycle C0

        // init sequence: {0,1} then {2,3}, busy for exactly two cycles
        @(negedge clk);
        check("c0_init_busy", init_busy, INIT_EN);
        check("c0_we_a", ram_we_a, INIT_EN);
        check("c0_addr_b", ram_addr_b, INIT_EN ? 1 : 0);
        step();
        @(negedge clk);
        check("c1_init_busy", init_busy, INIT_EN);
        check("c1_addr_a", ram_addr_a, INIT_EN ? 2 : 0);
        check("c1_addr_b", ram_addr_b, INIT_EN ? 3 : 0);
        step();
        host_req = 1; host_we = 0; host_addr = 2'd3;
        @(negedge clk);
        check("c2_init_busy", init_busy, 0);
        check("host_rd3_gnt", host_gnt, 1);
        step(); idle();
        @(negedge clk);
        check("host_rd3_rvalid", host_rvalid, 1);
        check("host_rd3_rdata", host_rdata, 16'h0000);

        // op write + op read of the same word: forwarded
        step();
        op_wr_req = 1; op_wr_addr = 2'd1; op_wr_data = 16'h005A;
        op_rd_req = 1; op_rd_addr = 2'd1;
        step(); idle();
        @(negedge clk);
        check("fwd_op_valid", op_rd_valid, 1);
        check("fwd_op_data", op_rd_data, 16'h005A);

        // host read on port B while the pipeline reads
        step();
        op_wr_req = 1; op_wr_addr = 2'd2; op_wr_data = 16'h0033;
        step();
        op_wr_req = 0;
        op_rd_req = 1; op_rd_addr = 2'd0;
        host_req = 1; host_we = 0; host_addr = 2'd2;
        @(negedge clk);
        check("hostb_gnt", host_gnt, 1);
        check("hostb_addr_b", ram_addr_b, 2);
        step();
        host_req = 0;
        @(negedge clk);
        check("hostb_rdata", host_rdata, 16'h0033);
        check("hostb_op_data", op_rd_data, 16'h0000);

        // both ports busy for 4 cycles: no grant, then granted on port B
        step();
        op_wr_req = 1; op_wr_addr = 2'd3;
        host_req = 1; host_we = 0; host_addr = 2'd1;
        for (int i = 0; i < 4; i++) begin
            op_wr_data = DW'(16'h0100 + i);
            @(negedge clk);
            check($sformatf("busy_gnt%0d", i), host_gnt, 0);
            step();
        end
        op_wr_req = 0;
        @(negedge clk);
        check("busy_release_gnt", host_gnt, 1);
        step(); idle();
        @(negedge clk);
        check("busy_rdata", host_rdata, 16'h005A);

        // host write collides with op write on the same word: refused, then retried
        step();
        op_wr_req = 1; op_wr_addr = 2'd2; op_wr_data = 16'h0011;
        host_req = 1; host_we = 1; host_addr = 2'd2; host_wdata = 16'h0022;
        @(negedge clk);
        check("coll_gnt", host_gnt, 0);
        step();
        op_wr_req = 0;
        @(negedge clk);
        check("coll_retry_gnt", host_gnt, 1);
        check("coll_mem_op", ram_mem[2], 16'h0011);
        step(); idle();
        @(negedge clk);
        check("coll_mem_host", ram_mem[2], 16'h0022);

        // host read on A forwarded from the op write
        step();
        op_wr_req = 1; op_wr_addr = 2'd0; op_wr_data = 16'h0077;
        host_req = 1; host_we = 0; host_addr = 2'd0;
        @(negedge clk);
        check("hfwd_gnt", host_gnt, 1);
        step(); idle();
        @(negedge clk);
        check("hfwd_rdata", host_rdata, 16'h0077);

        // op read forwarded from a host write on B
        step();
        op_rd_req = 1; op_rd_addr = 2'd3;
        host_req = 1; host_we = 1; host_addr = 2'd3; host_wdata = 16'h0099;
        @(negedge clk);
        check("ofwd_we_b", ram_we_b, 1);
        step(); idle();
        @(negedge clk);
        check("ofwd_op_data", op_rd_data, 16'h0099);

        // reset with a read in flight
        step();
        op_rd_req = 1; op_rd_addr = 2'd1;
        step(); idle();
        rst = 1;
        @(negedge clk);
        check("inflight_cleared", op_rd_valid, 0);
        step();
        rst = 0;
        op_rd_req = 1; op_rd_addr = 2'd0;            // dropped if INIT present
        step(); idle();
        #1;
        check("drop_err", err_drop, INIT_EN);
        check("drop_no_valid", op_rd_valid, !INIT_EN);
        #1 rst = 1;                                  // mid-INIT reset
        step();
        rst = 0;
        @(negedge clk);
        check("restart_busy", init_busy, INIT_EN);
        check("restart_err", err_drop, 0);
        check("restart_we_a", ram_we_a, INIT_EN);
        check("restart_addr_b", ram_addr_b, INIT_EN ? 1 : 0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
